// File: rtl/muon_daq_pkg.sv
// Shared DAQ definitions: event saver state encoding, event ID width and the
// default event geometry shared with the downstream event FIFO.
package muon_daq_pkg;

    localparam int EVT_ID_W    = 32;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_N_WORDS = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        HEADER,
        PAYLOAD,
        DONE
    } saver_state_t;

endpackage

// File: rtl/event_saver_hdr_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high clear
//   inc   - increment request for this cycle
//   count - current count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/event_saver_hdr.sv
// event_saver_hdr: snapshots an N_WORDS x DATA_W event on trigger and writes
// it word by word into a FIFO write port, optionally preceded by a header word
// {event_id, timestamp}. Waits at most FULL_TIMEOUT cycles for FIFO space
// before the first word, then stalls indefinitely per word once started.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   trigger        - event trigger level
//   event_i        - flat payload, word k at [k*DATA_W +: DATA_W], word 0 first
//   full_i         - FIFO full flag
//   wr_en_o, din_o - FIFO write port (din_o is 0 when not writing)
//   event_saved    - pulse in the cycle after the last word is written
//   event_dropped  - pulse when an event is discarded on timeout
//   busy_o         - high whenever not idle
//   event_id_o     - ID of the most recently accepted trigger
//   lost_count_o   - triggers seen while busy (saturating)
//   drop_count_o   - events dropped on timeout (saturating)
module event_saver_hdr
    import muon_daq_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int N_WORDS      = DEF_N_WORDS,
    parameter int HEADER_EN    = 1,
    parameter int TS_W         = 32,
    parameter int FULL_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trigger,
    input  logic [N_WORDS*DATA_W-1:0] event_i,
    input  logic                      full_i,
    output logic                      wr_en_o,
    output logic [DATA_W-1:0]         din_o,
    output logic                      event_saved,
    output logic                      event_dropped,
    output logic                      busy_o,
    output logic [EVT_ID_W-1:0]       event_id_o,
    output logic [CNT_W-1:0]          lost_count_o,
    output logic [CNT_W-1:0]          drop_count_o
);

    localparam int ID_FW = DATA_W - TS_W;
    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int TO_W  = (FULL_TIMEOUT > 1) ? $clog2(FULL_TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FULL_TIMEOUT - 1);

    saver_state_t state, state_next;

    logic [N_WORDS*DATA_W-1:0] snapshot;
    logic [TS_W-1:0]           ts;
    logic [TS_W-1:0]           ts_snap;
    logic [EVT_ID_W-1:0]       event_id;
    logic [IDX_W-1:0]          idx;
    logic [TO_W-1:0]           to_cnt;
    logic                      accept;
    logic [DATA_W-1:0]         header_word;

    // ID field is truncated or zero-extended to whatever room the timestamp leaves.
    assign header_word = {ID_FW'(event_id), ts_snap};
    assign busy_o      = (state != IDLE);
    assign event_id_o  = event_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        wr_en_o       = 1'b0;
        din_o         = '0;
        event_saved   = 1'b0;
        event_dropped = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    accept     = 1'b1;
                    state_next = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (!full_i) begin
                    state_next = (HEADER_EN != 0) ? HEADER : PAYLOAD;
                end else if (to_cnt == TO_LAST) begin
                    event_dropped = 1'b1;
                    state_next    = IDLE;
                end
            end
            HEADER: begin
                if (!full_i) begin
                    wr_en_o    = 1'b1;
                    din_o      = header_word;
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!full_i) begin
                    wr_en_o = 1'b1;
                    din_o   = snapshot[idx*DATA_W +: DATA_W];
                    if (idx == LAST_IDX) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                event_saved = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot <= '0;
            ts       <= '0;
            ts_snap  <= '0;
            event_id <= '0;
            idx      <= '0;
            to_cnt   <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (accept) begin
                snapshot <= event_i;
                ts_snap  <= ts;
                event_id <= event_id + 1'b1;
                idx      <= '0;
                to_cnt   <= '0;
            end
            if ((state == WAIT_SPACE) && full_i && (to_cnt != TO_LAST)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if ((state == PAYLOAD) && wr_en_o) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_lost_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (trigger && (state != IDLE)),
        .count (lost_count_o)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (event_dropped),
        .count (drop_count_o)
    );

endmodule

// File: tb/tb_event_saver_hdr.sv
// Self-checking bench for event_saver_hdr. Instance a: 64-bit words, 16 words,
// header on, FULL_TIMEOUT=8. Instance b: 32-bit words, 4 words, no header,
// FULL_TIMEOUT=4, 3-bit status counters.
module tb_event_saver_hdr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance a ----------------
    logic              rst_a = 1'b1, trig_a = 1'b0, full_a = 1'b0;
    logic [16*64-1:0]  ev_a = '0;
    logic              wr_a, saved_a, dropped_a, busy_a;
    logic [63:0]       din_a;
    logic [31:0]       id_a;
    logic [15:0]       lost_a, drop_a;

    event_saver_hdr #(.DATA_W(64), .N_WORDS(16), .HEADER_EN(1), .TS_W(32),
                      .FULL_TIMEOUT(8), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst_a), .trigger(trig_a), .event_i(ev_a), .full_i(full_a),
        .wr_en_o(wr_a), .din_o(din_a), .event_saved(saved_a), .event_dropped(dropped_a),
        .busy_o(busy_a), .event_id_o(id_a), .lost_count_o(lost_a), .drop_count_o(drop_a)
    );

    // ---------------- instance b ----------------
    logic              rst_b = 1'b1, trig_b = 1'b0, full_b = 1'b0;
    logic [4*32-1:0]   ev_b = '0;
    logic              wr_b, saved_b, dropped_b, busy_b;
    logic [31:0]       din_b;
    logic [31:0]       id_b;
    logic [2:0]        lost_b, drop_b;

    event_saver_hdr #(.DATA_W(32), .N_WORDS(4), .HEADER_EN(0), .TS_W(16),
                      .FULL_TIMEOUT(4), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst_b), .trigger(trig_b), .event_i(ev_b), .full_i(full_b),
        .wr_en_o(wr_b), .din_o(din_b), .event_saved(saved_b), .event_dropped(dropped_b),
        .busy_o(busy_b), .event_id_o(id_b), .lost_count_o(lost_b), .drop_count_o(drop_b)
    );

    // Reference timestamp for instance a: free-running, cleared by reset.
    logic [31:0] ts_m = '0;
    always @(posedge clk) ts_m <= rst_a ? 32'd0 : ts_m + 32'd1;

    // Scoreboards and output monitors.
    logic [63:0] q_a[$];
    logic [31:0] q_b[$];
    int  nwr_a = 0, nwr_b = 0;
    bit  mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_a) begin
                nwr_a++;
                if (q_a.size() == 0) check("a_unexpected_write", din_a, 64'hDEAD_0000_0000_DEAD);
                else                 check("a_data", din_a, q_a.pop_front());
            end else begin
                check("a_din_idle", din_a, 64'd0);
            end
            if (wr_b) begin
                nwr_b++;
                if (q_b.size() == 0) check("b_unexpected_write", {32'd0, din_b}, 64'hDEAD);
                else                 check("b_data", {32'd0, din_b}, {32'd0, q_b.pop_front()});
            end else begin
                check("b_din_idle", {32'd0, din_b}, 64'd0);
            end
        end
    end

    task automatic load_a(input logic [31:0] id, input logic [63:0] base);
        q_a.push_back({id, ts_m});
        for (int k = 0; k < 16; k++) begin
            ev_a[k*64 +: 64] = base + 64'(k);
            q_a.push_back(base + 64'(k));
        end
    endtask

    task automatic load_b(input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            ev_b[k*32 +: 32] = base + 32'(k);
            q_b.push_back(base + 32'(k));
        end
    endtask

    task automatic wait_saved_a(input string tag, input int max);
        int n = 0;
        while (saved_a !== 1'b1 && n < max) begin tick(); n++; end
        check(tag, {63'd0, saved_a}, 64'd1);
    endtask

    task automatic wait_saved_b(input string tag, input int max);
        int n = 0;
        while (saved_b !== 1'b1 && n < max) begin tick(); n++; end
        check(tag, {63'd0, saved_b}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset both instances.
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        mon_en = 1'b1;
        check("a_rst_busy", {63'd0, busy_a}, 0);
        check("a_rst_wr", {63'd0, wr_a}, 0);
        check("a_rst_id", {32'd0, id_a}, 0);
        check("a_rst_lost", {48'd0, lost_a}, 0);
        check("a_rst_drop", {48'd0, drop_a}, 0);
        check("a_rst_pulses", {62'd0, saved_a, dropped_a}, 0);
        check("b_rst_busy", {63'd0, busy_b}, 0);

        // Single event, no backpressure; event_i scrambled after capture.
        base = nwr_a;
        load_a(32'd1, 64'h1000);
        trig_a = 1'b1; tick(); trig_a = 1'b0;
        ev_a = '1;
        check("a_wait_nowr", {63'd0, wr_a}, 0);
        check("a_busy", {63'd0, busy_a}, 1);
        check("a_id1", {32'd0, id_a}, 1);
        tick();
        check("a_first_wr", {63'd0, wr_a}, 1);
        repeat (17) tick();
        check("a_saved_timing", {63'd0, saved_a}, 1);
        check("a_nwr17", 64'(nwr_a - base), 17);
        tick();
        check("a_idle_after", {63'd0, busy_a}, 0);
        check("a_saved_once", {63'd0, saved_a}, 0);

        // full_i toggling every cycle.
        base = nwr_a;
        load_a(32'd2, 64'h2000);
        trig_a = 1'b1; tick(); trig_a = 1'b0;
        n = 0;
        while (saved_a !== 1'b1 && n < 100) begin full_a = ~full_a; tick(); n++; end
        full_a = 1'b0;
        check("a_toggle_saved", {63'd0, saved_a}, 1);
        check("a_toggle_nwr", 64'(nwr_a - base), 17);
        tick();

        // Trigger held 5 cycles after a fresh reset.
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        load_a(32'd1, 64'h3000);
        trig_a = 1'b1; repeat (5) tick(); trig_a = 1'b0;
        check("a_lost4", {48'd0, lost_a}, 4);
        check("a_hold_id", {32'd0, id_a}, 1);
        wait_saved_a("a_hold_saved", 40);
        tick();

        // Timeout: full held from trigger.
        base = nwr_a;
        full_a = 1'b1;
        trig_a = 1'b1; tick(); trig_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("a_no_early_drop", {63'd0, dropped_a}, 0);
            tick();
        end
        check("a_dropped", {63'd0, dropped_a}, 1);
        tick();
        full_a = 1'b0;
        check("a_drop_idle", {63'd0, busy_a}, 0);
        check("a_drop_cnt", {48'd0, drop_a}, 1);
        check("a_drop_nowr", 64'(nwr_a - base), 0);
        check("a_drop_id", {32'd0, id_a}, 2);

        // Reset during payload word 5.
        load_a(32'd3, 64'h4000);
        trig_a = 1'b1; tick(); trig_a = 1'b0;
        tick();
        repeat (6) tick();
        check("a_word5_wr", {63'd0, wr_a}, 1);
        check("a_word5_data", din_a, 64'h4005);
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        q_a.delete();
        check("a_abort_wr", {63'd0, wr_a}, 0);
        check("a_abort_lost", {48'd0, lost_a}, 0);
        check("a_abort_drop", {48'd0, drop_a}, 0);
        check("a_abort_id", {32'd0, id_a}, 0);
        for (int i = 0; i < 3; i++) begin
            check("a_abort_quiet", {61'd0, saved_a, dropped_a, wr_a}, 0);
            tick();
        end
        base = nwr_a;
        load_a(32'd1, 64'h5000);
        trig_a = 1'b1; tick(); trig_a = 1'b0;
        wait_saved_a("a_post_rst_saved", 40);
        check("a_post_rst_id", {32'd0, id_a}, 1);
        check("a_post_rst_nwr", 64'(nwr_a - base), 17);
        tick();

        // Instance b: payload only.
        base = nwr_b;
        load_b(32'hB000);
        trig_b = 1'b1; tick(); trig_b = 1'b0;
        check("b_id1", {32'd0, id_b}, 1);
        wait_saved_b("b_saved", 20);
        check("b_nwr4", 64'(nwr_b - base), 4);
        tick();
        check("b_idle", {63'd0, busy_b}, 0);

        // Instance b: mid-event stall with trigger held, lost counter saturates.
        base = nwr_b;
        load_b(32'hC000);
        trig_b = 1'b1; tick(); tick();
        full_b = 1'b1;
        repeat (10) tick();
        trig_b = 1'b0;
        check("b_lost_sat", {61'd0, lost_b}, 7);
        check("b_stall_busy", {63'd0, busy_b}, 1);
        full_b = 1'b0;
        wait_saved_b("b_stall_saved", 20);
        check("b_stall_nwr", 64'(nwr_b - base), 4);
        tick();

        // Instance b: timeout of 4 cycles.
        full_b = 1'b1;
        trig_b = 1'b1; tick(); trig_b = 1'b0;
        repeat (3) tick();
        check("b_dropped", {63'd0, dropped_b}, 1);
        tick();
        full_b = 1'b0;
        check("b_drop_cnt", {61'd0, drop_b}, 1);
        check("b_drop_idle", {63'd0, busy_b}, 0);

        tick();
        check("a_queue_empty", 64'(q_a.size()), 0);
        check("b_queue_empty", 64'(q_b.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
